// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and types for the TDM demultiplexer receiver.
//
// Optional feature macro: TDM_PARITY_EN
//   undefined -> frame is N_CH slots of data
//   defined   -> frame is N_CH data slots plus one even-parity slot (PAR_SLOT)
//
// Contents:
//   N_CH      channels (data slots) per frame
//   N_SLOT    total slots per frame, including the parity slot when enabled
//   SLOT_W    slot index width, wide enough to hold N_SLOT-1
//   LAST_SLOT index of the final slot of a frame
//   state_t   receiver state {HUNT, RUN}
package tdm_pkg;

  localparam int N_CH = 4;

`ifdef TDM_PARITY_EN
  localparam int PAR_SLOT = N_CH;
  localparam int N_SLOT   = N_CH + 1;
`else
  localparam int N_SLOT   = N_CH;
`endif

  localparam int SLOT_W = $clog2(N_SLOT);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOT - 1);

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: slot index counter for the TDM receiver.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (slot -> 0)
//   en         advance one slot, wrapping to 0 after LAST_SLOT
//   load1      force slot to 1 (the slot-0 bit was just taken with sync)
//   clr        force slot to 0
//   slot       current (next expected) slot index
//   last_slot  high while slot == LAST_SLOT
//
// Priority: rst/clr over load1 over en.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  assign last_slot = (slot == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (en) begin
      slot <= last_slot ? '0 : slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: receive end of a 4-channel TDM link.
//
// Collects one serial bit per slot into a shadow register and, on the last
// slot of a frame, transfers the complete word to d with a one-cycle
// frame_valid pulse. A frame-sync pulse marks slot 0. The receiver hunts for
// sync (HUNT), then tracks slots (RUN); a missing sync drops back to HUNT,
// an early sync restarts the frame while staying in RUN.
//
// Optional feature macro: TDM_PARITY_EN
//   defined -> one extra even-parity slot per frame; a bad parity frame is
//              discarded with a par_err pulse. Undefined -> par_err is 0.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   din          serial channel bit for the current slot
//   in_valid     din and sync are sampled only when high
//   sync         high with the slot-0 bit of every frame
//   d            last complete frame, d[k] = channel k
//   frame_valid  one-cycle pulse when d updates
//   locked       high while in RUN (exposes the FSM state)
//   slot         next expected slot index
//   sync_err     one-cycle pulse on a missing or early sync
//   par_err      one-cycle pulse on a parity failure
//
// Handshake: in_valid is a qualifier only (no backpressure); every cycle with
// in_valid high consumes exactly one slot, so frames may arrive back to back.
module tdm_demux_rx
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              in_valid,
  input  logic              sync,
  output logic [N_CH-1:0]   d,
  output logic              frame_valid,
  output logic              locked,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err,
  output logic              par_err
);

  state_t            state;
  logic [N_CH-1:0]   shadow;

  logic              ctr_en;
  logic              ctr_load1;
  logic              ctr_clr;
  logic              last_slot;
  logic              slot_zero;

  assign slot_zero = (slot == '0);
  assign locked    = (state == RUN);

  // Slot counter control derived from the same decision tree as the FSM.
  always_comb begin
    ctr_en    = 1'b0;
    ctr_load1 = 1'b0;
    ctr_clr   = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (sync) ctr_load1 = 1'b1;
        end
        RUN: begin
          if (sync)           ctr_load1 = 1'b1;
          else if (slot_zero) ctr_clr   = 1'b1;
          else                ctr_en    = 1'b1;
        end
        default: ctr_clr = 1'b1;
      endcase
    end
  end

  tdm_slot_ctr u_slot_ctr (
    .clk       (clk),
    .rst       (rst),
    .en        (ctr_en),
    .load1     (ctr_load1),
    .clr       (ctr_clr),
    .slot      (slot),
    .last_slot (last_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      shadow      <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err     <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err     <= 1'b0;
`endif
      if (in_valid) begin
        case (state)
          HUNT: begin
            if (sync) begin
              shadow[0] <= din;
              state     <= RUN;
            end
          end
          RUN: begin
            if (sync) begin
              // Normal frame start, or early sync: either way restart at slot 1.
              shadow[0] <= din;
              if (!slot_zero) sync_err <= 1'b1;
            end else if (slot_zero) begin
              // Missing sync: drop lock, keep the last good frame on d.
              sync_err <= 1'b1;
              state    <= HUNT;
            end else begin
              // Data slots only; the parity slot index never matches a channel.
              for (int k = 1; k < N_CH; k++) begin
                if (slot == SLOT_W'(k)) shadow[k] <= din;
              end
`ifdef TDM_PARITY_EN
              if (last_slot) begin
                if ((^{shadow, din}) == 1'b0) begin
                  d           <= shadow;
                  frame_valid <= 1'b1;
                end else begin
                  par_err <= 1'b1;
                end
              end
`else
              // The last channel bit is still on din, so bypass the shadow.
              if (last_slot) begin
                d           <= {din, shadow[N_CH-2:0]};
                frame_valid <= 1'b1;
              end
`endif
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifndef TDM_PARITY_EN
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: self-checking bench for tdm_demux_rx.
//
// A queue-of-bits reference model predicts, per sampled cycle, the visible
// receiver status and the stream of frame / error events. A monitor on the
// falling edge pops those expectations and compares them with the DUT.
module tb_tdm_demux_rx;
  import tdm_pkg::*;

  localparam int EW = 2 + N_CH;                 // event: {kind, data}
  localparam int SW = 1 + SLOT_W + 3 + N_CH;    // status: {locked, slot, fv, se, pe, d}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic in_valid = 1'b0;
  logic sync = 1'b0;

  logic [N_CH-1:0]   d;
  logic              frame_valid;
  logic              locked;
  logic [SLOT_W-1:0] slot;
  logic              sync_err;
  logic              par_err;

  always #5 clk = ~clk;

  tdm_demux_rx dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .in_valid    (in_valid),
    .sync        (sync),
    .d           (d),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
    .sync_err    (sync_err),
    .par_err     (par_err)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] st_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: lock flag, bits gathered so far in this frame, last word.
  bit              m_locked;
  bit              m_bits[$];
  logic [N_CH-1:0] m_d;

  task automatic push_status(input bit fv, input bit se, input bit pe);
    logic [SLOT_W-1:0] s;
    s = m_locked ? SLOT_W'(m_bits.size()) : '0;
    st_q.push_back({m_locked, s, fv, se, pe, m_d});
  endtask

  task automatic model_step(input bit v, input bit s, input bit b);
    bit fv, se, pe;
    logic [N_CH-1:0] w;
    int ones;
    fv = 0; se = 0; pe = 0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_bits.delete();
          m_bits.push_back(b);
          m_locked = 1;
        end
      end else if (s) begin
        if (m_bits.size() != 0) begin
          se = 1;
          exp_q.push_back({2'd1, N_CH'(0)});
        end
        m_bits.delete();
        m_bits.push_back(b);
      end else if (m_bits.size() == 0) begin
        se = 1;
        exp_q.push_back({2'd1, N_CH'(0)});
        m_locked = 0;
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == N_SLOT) begin
          w = '0;
          ones = 0;
          for (int i = 0; i < N_CH; i++) w[i] = m_bits[i];
          for (int i = 0; i < N_SLOT; i++) ones += int'(m_bits[i]);
          if (N_SLOT > N_CH && (ones % 2) == 1) begin
            pe = 1;
            exp_q.push_back({2'd2, N_CH'(0)});
          end else begin
            fv = 1;
            m_d = w;
            exp_q.push_back({2'd0, w});
          end
          m_bits.delete();
        end
      end
    end
    push_status(fv, se, pe);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input bit s, input bit b);
    in_valid = v;
    sync     = s;
    din      = b;
    @(posedge clk);
    model_step(v, s, b);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    sync     = 1'b0;
    din      = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_locked = 0;
      m_bits.delete();
      m_d = '0;
      push_status(0, 0, 0);
      #1;
    end
    rst = 1'b0;
  endtask

  // One frame; optional stall of stall_n idle cycles just before slot stall_at.
  task automatic send_frame(input logic [N_CH-1:0] data, input int stall_at,
                            input int stall_n, input bit par_ok);
    bit b;
    for (int k = 0; k < N_SLOT; k++) begin
      if (k == stall_at) begin
        for (int j = 0; j < stall_n; j++) drive(0, 1'($urandom), 1'($urandom));
      end
      if (k < N_CH) b = data[k];
      else          b = (^data) ^ !par_ok;
      drive(1, k == 0, b);
    end
  endtask

  // ---------------- monitor ----------------
  logic [SW-1:0] mon_st_exp, mon_st_act;
  logic [EW-1:0] mon_ev_exp, mon_ev_act;

  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      mon_st_exp = st_q.pop_front();
      mon_st_act = {locked, slot, frame_valid, sync_err, par_err, d};
      n_cmp++;
      if (mon_st_act !== mon_st_exp) begin
        n_err++;
        $display("FAIL status {locked,slot,fv,se,pe,d} @%0t: got %b want %b",
                 $time, mon_st_act, mon_st_exp);
      end
    end
    if (frame_valid === 1'b1 || sync_err === 1'b1 || par_err === 1'b1) begin
      if (sync_err)     mon_ev_act = {2'd1, N_CH'(0)};
      else if (par_err) mon_ev_act = {2'd2, N_CH'(0)};
      else              mon_ev_act = {2'd0, d};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL event @%0t: got %b want none", $time, mon_ev_act);
      end else begin
        mon_ev_exp = exp_q.pop_front();
        if (mon_ev_act !== mon_ev_exp) begin
          n_err++;
          $display("FAIL event @%0t: got %b want %b", $time, mon_ev_act, mon_ev_exp);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r, plen;
    m_locked = 0;
    m_d = '0;

    do_reset(2);

    // Lock and capture, back to back.
    send_frame(4'b1101, -1, 0, 1);
    send_frame(4'b0010, -1, 0, 1);

    // Stall between slot1 and slot2.
    send_frame(4'b1101, 2, 3, 1);

    // Missing sync, some discarded HUNT bits, then recovery.
    drive(1, 0, 1);
    drive(1, 0, 0);
    drive(1, 0, 1);
    send_frame(4'b0110, -1, 0, 1);

    // Early sync at slot2, then a full new frame.
    drive(1, 1, 1);
    drive(1, 0, 0);
    send_frame(4'b1011, -1, 0, 1);

`ifdef TDM_PARITY_EN
    send_frame(4'b1011, -1, 0, 1);
    send_frame(4'b1011, -1, 0, 0);
`endif

    // Reset mid-frame, bits before sync must be ignored.
    drive(1, 1, 1);
    drive(1, 0, 1);
    do_reset(1);
    drive(1, 0, 1);
    send_frame(4'b1001, -1, 0, 1);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        drive(1, 0, 1'($urandom));
      end else if (r == 1) begin
        plen = $urandom_range(1, N_SLOT - 1);
        for (int k = 0; k < plen; k++) drive(1, k == 0, 1'($urandom));
      end else if (r == 2) begin
        drive(0, 1'($urandom), 1'($urandom));
      end else begin
        send_frame(N_CH'($urandom), $urandom_range(0, N_SLOT + 2),
                   $urandom_range(1, 3), $urandom_range(0, 4) != 0);
      end
    end

    drive(0, 0, 0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || st_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d events / %0d status left want 0 / 0",
               exp_q.size(), st_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of a 4-channel time-division link; the transmit end is a 4:1 mux that steps its select across channels.
- Takes one serial data bit per slot, with a frame-sync pulse marking slot 0.
- Rebuilds the 4-bit parallel word and flags each completed frame.
- Sits between the serial link pin logic and the downstream parallel consumer.

Parameters:
- N_CH, 4, channels (slots) per frame.
- SLOT_W, 2, slot index width; equals clog2(N_CH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial channel bit for the current slot.
- in_valid  input  1  din and sync are sampled only when high.
- sync  input  1  high with the slot-0 bit of every frame.
- d  output  N_CH  last complete frame; d[k] = channel k.
- frame_valid  output  1  one-cycle pulse when d updates.
- locked  output  1  high while the state machine is in RUN.
- slot  output  SLOT_W  next expected slot index.
- sync_err  output  1  one-cycle pulse on a sync violation.
- par_err  output  1  parity error pulse; tied 0 unless TDM_PARITY_EN is defined.

Behaviour:
- One clock domain. Reset is synchronous and active-high. The clock port is clk and the reset port is rst.
- Reset values: d=0, frame_valid=0, locked=0, slot=0, sync_err=0, par_err=0, state=HUNT, shadow register=0.
- in_valid=0: all state, slot and d hold; frame_valid, sync_err and par_err go to 0 (they are pulses).
- State HUNT (locked=0):
  - in_valid&&!sync: din is discarded.
  - in_valid&&sync: shadow[0]<=din, slot<=1, next state RUN.
- State RUN (locked=1), on each in_valid:
  - slot!=0 and sync=0: shadow[slot]<=din, slot<=slot+1.
  - slot==N_CH-1: also d<={din, shadow[N_CH-2:0]}. frame_valid is high in the cycle after that edge. slot wraps to 0.
  - slot==0 and sync=1: normal frame start; shadow[0]<=din, slot<=1.
  - slot==0 and sync=0 (missing sync): sync_err pulse, din discarded, slot<=0, next state HUNT. d is retained.
  - slot!=0 and sync=1 (early sync): sync_err pulse, partial frame discarded, shadow[0]<=din, slot<=1, stay in RUN (resync).
- Latency: d and frame_valid are valid one cycle after the clock edge that samples the last slot.
- d changes only on a frame completion. Bits from partially received frames never reach d.
- Reset mid-frame: all partial data is lost and the next frame is accepted only after a sync.
- Back-to-back frames: sustain one slot per cycle with no bubble required.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Frame is N_CH+1 slots; slot N_CH carries even parity over the data bits.
  - slot counts 0..N_CH, so SLOT_W must be sized to hold N_CH.
  - On the parity slot, if ^{data,parity}==0: d updates and frame_valid pulses.
  - Otherwise: d holds, frame_valid stays 0, par_err pulses one cycle, and the machine stays in RUN.
- Undefined: frame is N_CH slots and par_err is constant 0. The port list is identical either way.

Decomposition:
- Package tdm_pkg holds:
  - constants N_CH and SLOT_W, with PAR_SLOT under the macro.
  - state typedef {HUNT, RUN}.
- One sub-module, tdm_slot_ctr: slot counter with enable, load-to-1, clear and wrap at the last slot; outputs last_slot.
- The top level holds the FSM, the shadow register, the output register and the error pulses.

Test Plan:
- Reset: assert rst 2 cycles -> d=0000, locked=0, slot=0, all pulses 0.
- Lock and capture: continuous in_valid; sync with din=1 in slot0, then din=0,1,1 -> locked=1 after first sample; d=1101 and frame_valid=1 one cycle after slot3; next frame 0010 -> d=0010.
- Stall: same frame with in_valid=0 for 3 cycles between slot1 and slot2 -> slot holds; d=1101 after completion; no extra frame_valid.
- Missing sync: after a good frame, slot0 presented with sync=0 -> sync_err=1 for one cycle, locked=0, d unchanged; recovers on the next sync.
- Early sync: sync asserted at slot2 -> sync_err pulse, slot=1, locked stays 1; the following 3 bits complete a new frame correctly.
- (TDM_PARITY_EN) Data 1011 with parity 1 -> d=1011; data 1011 with parity 0 -> par_err pulse, d unchanged, no frame_valid.
